trap_csr_unit: RTL and testbench

- Machine-mode CSR and trap-state block: the receiving end of the writeback stage's CSR-write, trap, mret and retire signals.
- Holds mstatus, mie, mip, mtvec, mepc, mcause, mscratch and the 64-bit cycle/instret counters.
- Returns gated interrupt requests (sip/tip/eip) to writeback.
- Supplies trap and mret target vectors to fetch and combinational CSR read data to decode/execute.

---
 rtl/trap_csr_unit.sv | 214 +++++++++++++++++++++
 tb/tb_trap_csr_unit.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_csr_unit.sv
// Machine-mode CSR file and trap state for one hart; optional macro MTVEC_VECTORED_EN enables vectored mtvec.
// Latency: CSR reads, interrupt requests and vectors are combinational; updates land on the next clk edge; ext_irq adds SYNC_STAGES cycles.
// Backpressure: none. Every input is consumed in the cycle it is presented.
// reset_n asserts asynchronously; its release is expected to come from an upstream reset synchronizer.
module trap_csr_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned HART_ID      = 0,
  parameter int unsigned SYNC_STAGES  = 2   // at least 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] read_address,
  output logic [31:0] read_data,
  output logic        read_illegal,
  input  logic        csr_write,
  input  logic [11:0] csr_address,
  input  logic [31:0] csr_data,
  input  logic        traped,
  input  logic        mret,
  input  logic        retired,
  input  logic [31:0] ecp,
  input  logic [3:0]  ecause,
  input  logic        interupt,
  input  logic        timer_irq,
  input  logic        ext_irq,
  output logic        sip,
  output logic        tip,
  output logic        eip,
  output logic [31:0] trap_vector,
  output logic [31:0] mret_vector
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTR   = 12'hB02;
  localparam logic [11:0] A_MINSTRH  = 12'hB82;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_CYCLEH   = 12'hC80;
  localparam logic [11:0] A_INSTR    = 12'hC02;
  localparam logic [11:0] A_INSTRH   = 12'hC82;
  localparam logic [11:0] A_MVENDOR  = 12'hF11;
  localparam logic [11:0] A_MARCH    = 12'hF12;
  localparam logic [11:0] A_MIMPID   = 12'hF13;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

`ifdef MTVEC_VECTORED_EN
  // MODE (bit0) is kept, bit1 is always zero
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
`else
  localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
`endif

  logic                   r_mstatus_mie;
  logic                   r_mpie;
  logic                   r_msie;
  logic                   r_mtie;
  logic                   r_meie;
  logic                   r_msip;
  logic [31:0]            r_mtvec;
  logic [31:0]            r_mepc;
  logic                   r_mcause_int;
  logic [3:0]             r_mcause_code;
  logic [31:0]            r_mscratch;
  logic [63:0]            r_mcycle;
  logic [63:0]            r_minstret;
  logic [SYNC_STAGES-1:0] r_sync;

  logic        w_meip_s;
  logic        w_wr;
  logic [63:0] w_mcycle_nxt;
  logic [63:0] w_minstret_nxt;
  logic [31:0] w_base;

  // A trap or mret in the same cycle wins over a CSR write, including counter writes.
  assign w_wr     = csr_write & ~traped & ~mret;
  assign w_meip_s = r_sync[SYNC_STAGES-1];

  // Bring the asynchronous external interrupt into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ext_irq};
    end
  end

  // Trap entry, mret and CSR write updates, highest priority first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mstatus_mie <= 1'b0;
      r_mpie        <= 1'b0;
      r_msie        <= 1'b0;
      r_mtie        <= 1'b0;
      r_meie        <= 1'b0;
      r_msip        <= 1'b0;
      r_mtvec       <= RESET_VECTOR & MTVEC_MASK;
      r_mepc        <= '0;
      r_mcause_int  <= 1'b0;
      r_mcause_code <= '0;
      r_mscratch    <= '0;
    end else if (traped) begin
      r_mepc        <= ecp & 32'hFFFF_FFFC;
      r_mcause_int  <= interupt;
      r_mcause_code <= ecause;
      r_mpie        <= r_mstatus_mie;
      r_mstatus_mie <= 1'b0;
    end else if (mret) begin
      r_mstatus_mie <= r_mpie;
      r_mpie        <= 1'b1;
    end else if (csr_write) begin
      case (csr_address)
        A_MSTATUS: begin
          r_mstatus_mie <= csr_data[3];
          r_mpie        <= csr_data[7];
        end
        A_MIE: begin
          r_msie <= csr_data[3];
          r_mtie <= csr_data[7];
          r_meie <= csr_data[11];
        end
        A_MTVEC:    r_mtvec    <= csr_data & MTVEC_MASK;
        A_MSCRATCH: r_mscratch <= csr_data;
        A_MEPC:     r_mepc     <= csr_data & 32'hFFFF_FFFC;
        A_MCAUSE: begin
          r_mcause_int  <= csr_data[31];
          r_mcause_code <= csr_data[3:0];
        end
        A_MIP:      r_msip     <= csr_data[3];
        default: ;
      endcase
    end
  end

  // Counter next values: a write replaces one half and suppresses the increment for that cycle.
  always_comb begin
    w_mcycle_nxt   = r_mcycle + 64'd1;
    w_minstret_nxt = r_minstret + {63'd0, retired};
    if (w_wr && csr_address == A_MCYCLE) begin
      w_mcycle_nxt = {r_mcycle[63:32], csr_data};
    end else if (w_wr && csr_address == A_MCYCLEH) begin
      w_mcycle_nxt = {csr_data, r_mcycle[31:0]};
    end
    if (w_wr && csr_address == A_MINSTR) begin
      w_minstret_nxt = {r_minstret[63:32], csr_data};
    end else if (w_wr && csr_address == A_MINSTRH) begin
      w_minstret_nxt = {csr_data, r_minstret[31:0]};
    end
  end

  // Free-running cycle and retired-instruction counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      r_mcycle   <= w_mcycle_nxt;
      r_minstret <= w_minstret_nxt;
    end
  end

  // Combinational CSR read port; unknown addresses flag illegal and read zero.
  always_comb begin
    read_data    = '0;
    read_illegal = 1'b0;
    case (read_address)
      A_MSTATUS:  read_data = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mstatus_mie, 3'd0};
      A_MISA:     read_data = 32'h4000_0100;
      A_MIE:      read_data = {20'd0, r_meie, 3'd0, r_mtie, 3'd0, r_msie, 3'd0};
      A_MTVEC:    read_data = r_mtvec;
      A_MSCRATCH: read_data = r_mscratch;
      A_MEPC:     read_data = r_mepc;
      A_MCAUSE:   read_data = {r_mcause_int, 27'd0, r_mcause_code};
      A_MIP:      read_data = {20'd0, w_meip_s, 3'd0, timer_irq, 3'd0, r_msip, 3'd0};
      A_MCYCLE,  A_CYCLE:  read_data = r_mcycle[31:0];
      A_MCYCLEH, A_CYCLEH: read_data = r_mcycle[63:32];
      A_MINSTR,  A_INSTR:  read_data = r_minstret[31:0];
      A_MINSTRH, A_INSTRH: read_data = r_minstret[63:32];
      A_MVENDOR, A_MARCH, A_MIMPID: read_data = '0;
      A_MHARTID:  read_data = 32'(HART_ID);
      default:    read_illegal = 1'b1;
    endcase
  end

  // Interrupt requests gated by the individual enables and global MIE.
  assign sip = r_msip    & r_msie & r_mstatus_mie;
  assign tip = timer_irq & r_mtie & r_mstatus_mie;
  assign eip = w_meip_s  & r_meie & r_mstatus_mie;

  assign w_base      = {r_mtvec[31:2], 2'b00};
  assign mret_vector = r_mepc;

  // Fetch target on trap: base address, or a per-cause slot for vectored interrupts.
`ifdef MTVEC_VECTORED_EN
  always_comb begin
    trap_vector = w_base;
    if (r_mtvec[0] && interupt) begin
      trap_vector = w_base + {26'd0, ecause, 2'b00};
    end
  end
`else
  always_comb begin
    trap_vector = w_base;
  end
`endif

endmodule

// File: tb/tb_trap_csr_unit.sv
// Bench for trap_csr_unit: directed steps followed by a randomized run,
// all compared against an architectural model of the machine-mode CSRs.
module tb_trap_csr_unit;
  localparam logic [31:0] RV  = 32'h8000_0000;
  localparam int unsigned HID = 5;
  localparam int unsigned SS  = 3;
`ifdef MTVEC_VECTORED_EN
  localparam logic [31:0] TV_MASK = 32'hFFFF_FFFD;
`else
  localparam logic [31:0] TV_MASK = 32'hFFFF_FFFC;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [11:0] read_address;
  logic [31:0] read_data;
  logic        read_illegal;
  logic        csr_write;
  logic [11:0] csr_address;
  logic [31:0] csr_data;
  logic        traped, mret, retired;
  logic [31:0] ecp;
  logic [3:0]  ecause;
  logic        interupt, timer_irq, ext_irq;
  logic        sip, tip, eip;
  logic [31:0] trap_vector, mret_vector;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  trap_csr_unit #(.RESET_VECTOR(RV), .HART_ID(HID), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset_n(reset_n), .read_address(read_address), .read_data(read_data),
    .read_illegal(read_illegal), .csr_write(csr_write), .csr_address(csr_address),
    .csr_data(csr_data), .traped(traped), .mret(mret), .retired(retired), .ecp(ecp),
    .ecause(ecause), .interupt(interupt), .timer_irq(timer_irq), .ext_irq(ext_irq),
    .sip(sip), .tip(tip), .eip(eip), .trap_vector(trap_vector), .mret_vector(mret_vector)
  );

  // Architectural model state
  bit          m_mie, m_mpie, m_msip;
  logic [31:0] m_mie_csr, m_mtvec, m_mepc, m_mcause, m_mscratch;
  logic [63:0] m_cyc, m_ins;
  bit          m_dly[$];   // ext_irq delay line; front is the synchronized level

  task automatic mdl_reset();
    m_mie = 0; m_mpie = 0; m_msip = 0;
    m_mie_csr = 0; m_mtvec = RV & TV_MASK; m_mepc = 0; m_mcause = 0; m_mscratch = 0;
    m_cyc = 0; m_ins = 0;
    m_dly.delete();
    for (int i = 0; i < SS; i++) m_dly.push_back(1'b0);
  endtask

  // Apply one clock of architectural behaviour from the current inputs.
  task automatic mdl_step();
    bit wr;
    logic [31:0] d;
    wr = csr_write && !traped && !mret;
    d  = csr_data;
    if (traped) begin
      m_mepc   = ecp & ~32'h3;
      m_mcause = {interupt, 27'd0, ecause};
      m_mpie   = m_mie;
      m_mie    = 0;
    end else if (mret) begin
      m_mie  = m_mpie;
      m_mpie = 1;
    end else if (wr) begin
      case (csr_address)
        12'h300: begin m_mie = d[3]; m_mpie = d[7]; end
        12'h304: m_mie_csr  = d & 32'h888;
        12'h305: m_mtvec    = d & TV_MASK;
        12'h340: m_mscratch = d;
        12'h341: m_mepc     = d & ~32'h3;
        12'h342: m_mcause   = d & 32'h8000_000F;
        12'h344: m_msip     = d[3];
        default: ;
      endcase
    end
    if (wr && csr_address == 12'hB00)      m_cyc[31:0]  = d;
    else if (wr && csr_address == 12'hB80) m_cyc[63:32] = d;
    else                                   m_cyc        = m_cyc + 64'd1;
    if (wr && csr_address == 12'hB02)      m_ins[31:0]  = d;
    else if (wr && csr_address == 12'hB82) m_ins[63:32] = d;
    else if (retired)                      m_ins        = m_ins + 64'd1;
    m_dly.push_back(ext_irq);
    void'(m_dly.pop_front());
  endtask

  task automatic exp_read(input logic [11:0] a, output logic [31:0] v, output logic ill);
    v = 0; ill = 0;
    case (a)
      12'h300: v = 32'h1800 | (m_mie ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0);
      12'h301: v = 32'h4000_0100;
      12'h304: v = m_mie_csr;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h344: v = (m_msip ? 32'h8 : 32'h0) | (timer_irq ? 32'h80 : 32'h0) | (m_dly[0] ? 32'h800 : 32'h0);
      12'hB00, 12'hC00: v = m_cyc[31:0];
      12'hB80, 12'hC80: v = m_cyc[63:32];
      12'hB02, 12'hC02: v = m_ins[31:0];
      12'hB82, 12'hC82: v = m_ins[63:32];
      12'hF11, 12'hF12, 12'hF13: v = 0;
      12'hF14: v = HID;
      default: ill = 1;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] ev, tv;
    logic ei;
    #1;
    exp_read(read_address, ev, ei);
    tv = m_mtvec & ~32'h3;
`ifdef MTVEC_VECTORED_EN
    if (m_mtvec[0] && interupt) tv = tv + 32'(ecause) * 4;
`endif
    chk({tag, ".rdata"}, read_data, ev);
    chk({tag, ".illegal"}, {31'd0, read_illegal}, {31'd0, ei});
    chk({tag, ".irq"}, {29'd0, sip, tip, eip},
        {29'd0, m_msip & m_mie_csr[3] & m_mie, timer_irq & m_mie_csr[7] & m_mie,
         m_dly[0] & m_mie_csr[11] & m_mie});
    chk({tag, ".trap_vec"}, trap_vector, tv);
    chk({tag, ".mret_vec"}, mret_vector, m_mepc);
  endtask

  task automatic tick();
    mdl_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
    csr_write = 1; csr_address = a; csr_data = d;
    tick();
    csr_write = 0;
  endtask

  task automatic rd(input logic [11:0] a, input string tag, input logic [31:0] exp);
    read_address = a;
    #1;
    chk(tag, read_data, exp);
  endtask

  logic [11:0] addrs [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                              12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                              12'hC02, 12'hC82, 12'hF12, 12'hF14, 12'h7C0, 12'h123};

  initial begin
    reset_n = 0; read_address = 12'h300; csr_write = 0; csr_address = 0; csr_data = 0;
    traped = 0; mret = 0; retired = 0; ecp = 0; ecause = 0; interupt = 0;
    timer_irq = 0; ext_irq = 0;
    mdl_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("in_reset");
    reset_n = 1;

    // Reset values
    check_all("post_reset");
    rd(12'h300, "rst_mstatus", 32'h1800);
    chk("rst_trap_vec", trap_vector, 32'h8000_0000);
    chk("rst_illegal_300", {31'd0, read_illegal}, 32'd0);
    read_address = 12'h7C0;
    check_all("illegal_7c0");
    chk("illegal_7c0_flag", {31'd0, read_illegal}, 32'd1);
    rd(12'hF14, "hartid", HID);
    rd(12'hF12, "marchid", 32'd0);

    // Timer interrupt and trap entry
    wr_csr(12'h300, 32'h8);
    timer_irq = 1;
    wr_csr(12'h304, 32'h80);
    check_all("tip_on");
    chk("tip_on_flag", {31'd0, tip}, 32'd1);
    traped = 1; interupt = 1; ecause = 7; ecp = 32'h104;
    tick();
    traped = 0;
    check_all("after_trap");
    chk("after_trap_tip", {31'd0, tip}, 32'd0);
    rd(12'h342, "trap_mcause", 32'h8000_0007);
    rd(12'h341, "trap_mepc", 32'h104);
    rd(12'h300, "trap_mstatus", 32'h1880);

    // mret restores MIE
    mret = 1;
    tick();
    mret = 0;
    check_all("after_mret");
    rd(12'h300, "mret_mstatus", 32'h1888);
    chk("mret_vec", mret_vector, 32'h104);

    // trap + mret + csr_write together: only the trap lands
    traped = 1; mret = 1; interupt = 0; ecause = 3; ecp = 32'h20B;
    csr_write = 1; csr_address = 12'h340; csr_data = 32'hDEAD_BEEF;
    tick();
    traped = 0; mret = 0; csr_write = 0;
    check_all("trap_mret");
    rd(12'h300, "tm_mstatus", 32'h1880);
    rd(12'h341, "tm_mepc", 32'h208);
    rd(12'h340, "tm_mscratch", 32'h0);

    // External interrupt latency through the synchronizer
    wr_csr(12'h300, 32'h8);
    wr_csr(12'h304, 32'h800);
    read_address = 12'h344;
    ext_irq = 1;
    for (int k = 1; k <= SS; k++) begin
      tick();
      check_all("ext_sync");
      chk("eip_latency", {31'd0, eip}, (k == SS) ? 32'd1 : 32'd0);
      chk("mip_meip", {31'd0, read_data[11]}, (k == SS) ? 32'd1 : 32'd0);
    end
    ext_irq = 0;

    // mcycle carry from lo into hi
    wr_csr(12'hB00, 32'hFFFF_FFFF);
    wr_csr(12'hB80, 32'h0);
    rd(12'hB00, "mcycle_lo_full", 32'hFFFF_FFFF);
    tick();
    rd(12'hB80, "mcycle_carry_hi", 32'h1);
    rd(12'hB00, "mcycle_carry_lo", 32'h0);
    check_all("mcycle_carry");

    // minstret counting and read-only alias
    wr_csr(12'hB02, 32'h0);
    wr_csr(12'hB82, 32'h0);
    retired = 1;
    repeat (5) tick();
    retired = 0;
    rd(12'hB02, "minstret_5", 32'd5);
    rd(12'hC02, "instret_alias_5", 32'd5);
    wr_csr(12'hC00, 32'h0);
    read_address = 12'hC00;
    check_all("c00_write_ignored");

    // mtvec mode handling
    wr_csr(12'h305, 32'h1001);
    interupt = 1; ecause = 11;
    check_all("mtvec_int");
`ifdef MTVEC_VECTORED_EN
    chk("vec_int_11", trap_vector, 32'h102C);
    rd(12'h305, "mtvec_read", 32'h1001);
`else
    chk("direct_int_11", trap_vector, 32'h1000);
    rd(12'h305, "mtvec_read", 32'h1000);
`endif
    interupt = 0; ecause = 2;
    check_all("mtvec_exc");
    chk("exc_base", trap_vector, 32'h1000);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      csr_write    = ($urandom_range(0, 2) == 0);
      csr_address  = addrs[$urandom_range(0, 19)];
      csr_data     = $urandom;
      traped       = ($urandom_range(0, 15) == 0);
      mret         = ($urandom_range(0, 15) == 0);
      retired      = $urandom_range(0, 1) != 0;
      ecp          = $urandom;
      ecause       = 4'($urandom_range(0, 15));
      interupt     = $urandom_range(0, 1) != 0;
      timer_irq    = ($urandom_range(0, 3) == 0);
      ext_irq      = $urandom_range(0, 1) != 0;
      read_address = addrs[$urandom_range(0, 19)];
      check_all("rand");
      tick();
    end
    csr_write = 0; traped = 0; mret = 0;
    check_all("rand_end");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
